fg_wave_shaper: RTL
===================

Name: fg_wave_shaper

Overview:
- Consumer side of the function-generator timer; sits between timer and output DAC/PWM stage.
- Samples the timer phase/counter on each qualified tick and maps it to a waveform: square, sawtooth, triangle or DC.
- Scales the waveform by an amplitude with an iterative shift-add multiplier, adds an offset, saturates, and emits one registered sample per tick.

Parameters:
- PHASE_BITWIDTH, 10, width of the incoming phase/counter value.
- AMP_BITWIDTH, 8, width of the amplitude word; also the multiplier iteration count.
- OUT_BITWIDTH, 10, width of sample/offset. Constraint: OUT_BITWIDTH <= PHASE_BITWIDTH+AMP_BITWIDTH.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  synchronous reset, active-high
- enable_i  in  1  0 = idle/abort, 1 = run
- waveSel_i  in  2  0 square, 1 sawtooth, 2 triangle, 3 DC
- phase_i  in  PHASE_BITWIDTH  timer counter value
- phaseValid_i  in  1  one-cycle tick qualifying phase_i (timer clk_en output)
- dutyCycle_i  in  PHASE_BITWIDTH  square threshold
- amplitude_i  in  AMP_BITWIDTH  gain, full scale = 2^AMP_BITWIDTH
- offset_i  in  OUT_BITWIDTH  unsigned offset added after scaling
- sample_o  out  OUT_BITWIDTH  registered output sample
- sampleValid_o  out  1  one-cycle pulse when sample_o updates
- busy_o  out  1  high while state != IDLE
- overrun_o  out  1  sticky: tick arrived while busy

Behaviour:
- Reset (rst_i=1 at an edge): state IDLE; sample_o=0, sampleValid_o=0, busy_o=0, overrun_o=0; internal registers cleared. Reset overrides all other inputs.
- FSM states: IDLE, MUL, OUT.
- IDLE: if enable_i && phaseValid_i, capture phase_i, waveSel_i, dutyCycle_i, amplitude_i and offset_i. Compute the shape value U. Clear the accumulator and iteration count. Go to MUL.
- Shape value U, unsigned, PHASE_BITWIDTH bits; M = all ones:
  - square: U = (phase < duty) ? M : 0. duty=0 gives always 0.
  - saw: U = phase.
  - triangle: t = {phase[P-2:0],1'b0}; U = phase[P-1] ? ~t : t.
  - DC: U = M.
- MUL: exactly AMP_BITWIDTH cycles, one amplitude bit per cycle, LSB first. Each bit adds U<<i to the accumulator. The accumulator is PHASE_BITWIDTH+AMP_BITWIDTH bits and cannot overflow. After the last bit, go to OUT.
- OUT: one cycle. scaled = product >> (PHASE_BITWIDTH+AMP_BITWIDTH-OUT_BITWIDTH). sum = scaled + offset, computed one bit wider. If the carry is set, sample_o = 2^OUT_BITWIDTH-1; else sample_o = sum. Assert sampleValid_o for one cycle. Return to IDLE.
- Latency: tick sampled at edge k -> sample_o and sampleValid_o visible after edge k+AMP_BITWIDTH+1.
- A tick is accepted in the cycle sampleValid_o is high (state IDLE). Minimum accepted tick spacing is AMP_BITWIDTH+2 clocks, i.e. timer prescaler >= AMP_BITWIDTH+1.
- Overrun: enable_i && phaseValid_i while in MUL or OUT -> tick dropped, overrun_o <= 1 (sticky). The in-flight sample completes normally.
- enable_i=0 at any edge:
  - state -> IDLE, sample_o <= 0, sampleValid_o <= 0, overrun_o <= 0.
  - In-flight computation is aborted with no valid pulse.
  - Ticks are ignored.
- Input changes after capture do not affect the in-flight sample.
- sample_o holds its last value between valid pulses.

Test Plan:
- Defaults, saw, phase=512, amp=255, offset=0, single tick -> sampleValid_o after 9 clocks, sample_o=510; busy_o high 9 cycles.
- Triangle, amp=128, offset=0: phase=768 -> sample_o=255; phase=256 -> U=512, sample_o=256.
- Square, duty=300, amp=255: phase=299, offset=10 -> 1019+10 saturates to 1023. phase=300 -> sample_o=10.
- DC, amp=0, offset=100 -> sample_o=100. Ticks every 10 clocks -> one valid per tick, overrun_o stays 0.
- Ticks spaced 5 clocks -> only alternate ticks produce samples, overrun_o=1 after the first dropped tick. Deassert enable_i -> overrun_o=0, sample_o=0.
- rst_i pulsed during MUL (cycle 4 after tick) -> next cycle all outputs 0, no valid pulse. The next tick produces a correct sample 9 clocks later.

Source files
------------

// File: rtl/fg_wave_shaper.sv
// Function-generator wave shaper: maps a qualified timer phase to a square/saw/triangle/DC
// shape, scales it with a serial shift-add multiplier, adds an offset and saturates.
module fg_wave_shaper #(
  parameter int PHASE_BITWIDTH = 10,
  parameter int AMP_BITWIDTH   = 8,
  parameter int OUT_BITWIDTH   = 10
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      enable_i,
  input  logic [1:0]                waveSel_i,
  input  logic [PHASE_BITWIDTH-1:0] phase_i,
  input  logic                      phaseValid_i,
  input  logic [PHASE_BITWIDTH-1:0] dutyCycle_i,
  input  logic [AMP_BITWIDTH-1:0]   amplitude_i,
  input  logic [OUT_BITWIDTH-1:0]   offset_i,
  output logic [OUT_BITWIDTH-1:0]   sample_o,
  output logic                      sampleValid_o,
  output logic                      busy_o,
  output logic                      overrun_o
);

  localparam int PROD_W = PHASE_BITWIDTH + AMP_BITWIDTH;
  localparam int SHIFT  = PROD_W - OUT_BITWIDTH;
  localparam int CNT_W  = $clog2(AMP_BITWIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_OUT} state_t;

  state_t                    state_q, state_d;
  logic [PROD_W-1:0]         acc_q;
  logic [PROD_W-1:0]         mcand_q;
  logic [AMP_BITWIDTH-1:0]   amp_q;
  logic [OUT_BITWIDTH-1:0]   offset_q;
  logic [CNT_W-1:0]          cnt_q;
  logic [OUT_BITWIDTH-1:0]   sample_q;
  logic                      valid_q;
  logic                      overrun_q;

  logic [PHASE_BITWIDTH-1:0] tri_t;
  logic [PHASE_BITWIDTH-1:0] shape_u;
  logic [OUT_BITWIDTH-1:0]   scaled_w;
  logic [OUT_BITWIDTH:0]     sum_w;
  logic                      last_bit;

  // Triangle folds the upper half of the phase ramp back down.
  assign tri_t    = {phase_i[PHASE_BITWIDTH-2:0], 1'b0};
  assign last_bit = (cnt_q == CNT_W'(AMP_BITWIDTH - 1));
  assign scaled_w = acc_q[PROD_W-1:SHIFT];
  assign sum_w    = {1'b0, scaled_w} + {1'b0, offset_q};

  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    shape_u = '1;
    unique case (waveSel_i)
      2'd0:    shape_u = (phase_i < dutyCycle_i) ? '1 : '0;
      2'd1:    shape_u = phase_i;
      2'd2:    shape_u = phase_i[PHASE_BITWIDTH-1] ? ~tri_t : tri_t;
      default: shape_u = '1;
    endcase
  end

  // NOTE: reset is synchronous, so it only takes effect on a clock edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (!enable_i) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE:  if (phaseValid_i) state_d = S_MUL;
        S_MUL:   if (last_bit) state_d = S_OUT;
        S_OUT:   state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_q     <= '0;
      mcand_q   <= '0;
      amp_q     <= '0;
      offset_q  <= '0;
      cnt_q     <= '0;
      sample_q  <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else if (!enable_i) begin
      sample_q  <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (phaseValid_i) begin
            mcand_q  <= PROD_W'(shape_u);
            amp_q    <= amplitude_i;
            offset_q <= offset_i;
            acc_q    <= '0;
            cnt_q    <= '0;
          end
        end
        S_MUL: begin
          // Multiplicand shifts left while the amplitude drains LSB first.
          if (amp_q[0]) acc_q <= acc_q + mcand_q;
          mcand_q <= mcand_q << 1;
          amp_q   <= amp_q >> 1;
          cnt_q   <= cnt_q + CNT_W'(1);
          if (phaseValid_i) overrun_q <= 1'b1;
        end
        S_OUT: begin
          sample_q <= sum_w[OUT_BITWIDTH] ? '1 : sum_w[OUT_BITWIDTH-1:0];
          valid_q  <= 1'b1;
          if (phaseValid_i) overrun_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    busy_o        = (state_q != S_IDLE);
    sample_o      = sample_q;
    sampleValid_o = valid_q;
    overrun_o     = overrun_q;
  end

endmodule
